// File: rtl/l1_dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate L1 data cache controller.
// One-word lines; a single outstanding next-level transaction; snoop invalidation from remote writers.
//
// state | meaning
// IDLE  | serve load hits combinationally, launch misses and stores
// FILL  | next-level read outstanding, waiting for mem_ack
// WRITE | write-through outstanding, waiting for mem_ack
// DONE  | one-cycle completion, cpu_rdata from response register
module l1_dcache_ctrl #(
    parameter int n     = 32,
    parameter int LINES = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [n-1:0] cpu_addr,
    input  logic [n-1:0] cpu_wdata,
    output logic [n-1:0] cpu_rdata,
    output logic         L1_busy,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [n-1:0] mem_rdata,
    input  logic         snoop_valid,
    input  logic [n-1:0] snoop_addr
);

    localparam int IW = $clog2(LINES);
    localparam int TW = n - IW - 2;

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;

    state_t           state;
    logic [LINES-1:0] valid;
    logic [TW-1:0]    tag_mem  [LINES];
    logic [n-1:0]     data_mem [LINES];
    logic [n-1:0]     resp;
    logic             fill_kill;

    logic [IW-1:0] cpu_idx, snp_idx, fill_idx;
    logic [TW-1:0] cpu_tag, snp_tag, fill_tag;
    logic          hit, snoop_hit, snoop_fill, store_hit, fill_done, idle;
    logic          unused_addr_bits;

    assign cpu_idx  = cpu_addr[IW+1:2];
    assign cpu_tag  = cpu_addr[n-1:IW+2];
    assign snp_idx  = snoop_addr[IW+1:2];
    assign snp_tag  = snoop_addr[n-1:IW+2];
    assign fill_idx = mem_addr[IW+1:2];
    assign fill_tag = mem_addr[n-1:IW+2];
    assign unused_addr_bits = ^{cpu_addr[1:0], snoop_addr[1:0]};

    assign idle       = (state == IDLE);
    assign hit        = cpu_req & valid[cpu_idx] & (tag_mem[cpu_idx] == cpu_tag);
    assign snoop_hit  = snoop_valid & valid[snp_idx] & (tag_mem[snp_idx] == snp_tag);
    assign snoop_fill = snoop_valid & (snoop_addr[n-1:2] == mem_addr[n-1:2]);
    assign store_hit  = idle & hit & cpu_we;
    assign fill_done  = (state == FILL) & mem_ack;

    assign L1_busy   = (state == FILL) | (state == WRITE) | (idle & cpu_req & (cpu_we | ~hit));
    assign cpu_rdata = (state == DONE) ? resp : data_mem[cpu_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            valid     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            resp      <= '0;
            fill_kill <= 1'b0;
        end else begin
            // Snoop clear comes first so a fill installing this edge overrides it.
            if (snoop_hit)
                valid[snp_idx] <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        mem_addr <= {cpu_addr[n-1:2], 2'b00};
                        if (cpu_we) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= cpu_wdata;
                            state     <= WRITE;
                        end else if (!hit) begin
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b0;
                            fill_kill <= 1'b0;
                            state     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (snoop_fill)
                        fill_kill <= 1'b1;
                    if (mem_ack) begin
                        valid[fill_idx] <= ~(fill_kill | snoop_fill);
                        resp            <= mem_rdata;
                        mem_req         <= 1'b0;
                        state           <= DONE;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (store_hit)
            data_mem[cpu_idx] <= cpu_wdata;
        if (fill_done) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_rdata;
        end
    end

endmodule
